// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: sequencer/arbiter in front of the SPART divisor buffer.
// Programs a 16-bit baud divisor (picked from a 4-entry table by br_cfg) as two
// byte writes on the shared bus (low byte at io_addr 2'b10, high byte at 2'b11),
// then waits for buf_rdy with a timeout. The same bus is lent to a host port
// whenever no configuration is pending.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   br_cfg                baud select, sampled when a config request is taken
//   cfg_start             single-cycle config request
//   host_req              host bus request (level)
//   host_wr/addr/data     host write strobe, address and data
//   buf_rdy               divisor buffer holds a complete divisor
//   host_gnt              host owns the bus
//   io_addr/baud_write/data_out  bus to divisor_buf (registered)
//   cfg_busy              config pending or in progress
//   cfg_done / cfg_err    one-cycle completion / timeout pulses
module baud_cfg_ctrl #(
  parameter logic [15:0] DIV0     = 16'h0515,
  parameter logic [15:0] DIV1     = 16'h028A,
  parameter logic [15:0] DIV2     = 16'h0144,
  parameter logic [15:0] DIV3     = 16'h00A1,
  parameter int unsigned TIMEOUT  = 16,
  parameter bit          AUTO_CFG = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       cfg_start,
  input  logic       host_req,
  input  logic       host_wr,
  input  logic [1:0] host_addr,
  input  logic [7:0] host_data,
  input  logic       buf_rdy,
  output logic       host_gnt,
  output logic [1:0] io_addr,
  output logic       baud_write,
  output logic [7:0] data_out,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err
);

  typedef enum logic [2:0] {StIdle, StHost, StWrLo, StWrHi, StWaitRdy} state_e;

  // Count value on the last permitted buf_rdy sample.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        auto_q;      // forces one request on the first edge after reset
  logic        pend_q;
  logic [15:0] pend_div_q;
  logic [15:0] div_q;
  logic [7:0]  wait_cnt_q;

  logic        start;
  logic [15:0] start_div;
  logic [15:0] sel_div;

  always_comb begin
    start_div = DIV0;
    case (br_cfg)
      2'b00:   start_div = DIV0;
      2'b01:   start_div = DIV1;
      2'b10:   start_div = DIV2;
      default: start_div = DIV3;
    endcase
  end

  assign start = cfg_start | auto_q;
  // A fresh request carries the newest br_cfg, so it overrides a pending one.
  assign sel_div = start ? start_div : pend_div_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      auto_q     <= AUTO_CFG;
      pend_q     <= 1'b0;
      pend_div_q <= 16'h0000;
      div_q      <= 16'h0000;
      wait_cnt_q <= 8'h00;
      host_gnt   <= 1'b0;
      io_addr    <= 2'b00;
      baud_write <= 1'b0;
      data_out   <= 8'h00;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      auto_q   <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start || pend_q) begin
            state_q    <= StWrLo;
            div_q      <= sel_div;
            pend_q     <= 1'b0;
            io_addr    <= 2'b10;
            data_out   <= sel_div[7:0];
            baud_write <= 1'b1;
            cfg_busy   <= 1'b1;
          end else if (host_req) begin
            state_q    <= StHost;
            host_gnt   <= 1'b1;
            baud_write <= 1'b0;
          end
        end

        StHost: begin
          if (host_req) begin
            io_addr    <= host_addr;
            data_out   <= host_data;
            baud_write <= host_wr;
          end else begin
            state_q    <= StIdle;
            host_gnt   <= 1'b0;
            baud_write <= 1'b0;
          end
        end

        StWrLo: begin
          state_q    <= StWrHi;
          io_addr    <= 2'b11;
          data_out   <= div_q[15:8];
          baud_write <= 1'b1;
        end

        StWrHi: begin
          state_q    <= StWaitRdy;
          baud_write <= 1'b0;
          wait_cnt_q <= 8'h00;
        end

        StWaitRdy: begin
          if (buf_rdy) begin
            state_q  <= StIdle;
            cfg_done <= 1'b1;
            cfg_busy <= pend_q;
          end else if (wait_cnt_q == WaitLast) begin
            state_q  <= StIdle;
            cfg_err  <= 1'b1;
            cfg_busy <= pend_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase

      // Requests arriving while the bus is owned are held until the next idle slot.
      if (start && (state_q != StIdle)) begin
        pend_q     <= 1'b1;
        pend_div_q <= start_div;
        cfg_busy   <= 1'b1;
      end
    end
  end

endmodule

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
- Sequencer and arbiter in front of the SPART baud divisor buffer (divisor_buf).
- Programs the 16-bit divisor as two byte writes on the shared io_addr/baud_write/data bus: low byte at io_addr=2'b10, then high byte at 2'b11.
- Selects the divisor from a 4-entry parameter table indexed by br_cfg, then waits for buf_rdy.
- Arbitrates the same bus between this internal config engine and a host (processor) write port.

Parameters:
- DIV0, 16'h0515, divisor for br_cfg=2'b00 (4800 baud at 100 MHz).
- DIV1, 16'h028A, divisor for br_cfg=2'b01 (9600).
- DIV2, 16'h0144, divisor for br_cfg=2'b10 (19200).
- DIV3, 16'h00A1, divisor for br_cfg=2'b11 (38400).
- TIMEOUT, 16, maximum WAIT_RDY cycles before error; range 1..255.
- AUTO_CFG, 1, when 1 a config sequence starts automatically after reset release.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- br_cfg  in  2  baud select, sampled when a config sequence is accepted
- cfg_start  in  1  single-cycle config request
- host_req  in  1  host requests bus ownership (level)
- host_wr  in  1  host write strobe, valid only while host_gnt=1
- host_addr  in  2  host io address
- host_data  in  8  host write data
- buf_rdy  in  1  divisor buffer holds a complete divisor
- host_gnt  out  1  host owns the bus
- io_addr  out  2  bus address to divisor_buf
- baud_write  out  1  bus write strobe
- data_out  out  8  bus write data
- cfg_busy  out  1  config sequence pending or active
- cfg_done  out  1  one-cycle pulse: config completed
- cfg_err  out  1  one-cycle pulse: buf_rdy timeout

Behaviour:
- All outputs are registered. Reset values are all zero: io_addr=2'b00, data_out=8'h00, baud_write, host_gnt, cfg_busy, cfg_done, cfg_err=0.
- rst low forces all outputs to their reset values immediately, clears pending state and returns the FSM to IDLE. A partially programmed divisor is abandoned.
- AUTO_CFG=1: the first clock edge after rst rises is treated as cfg_start with the current br_cfg.
- FSM states: IDLE, HOST, WR_LO, WR_HI, WAIT_RDY.
- IDLE arbitration, evaluated each edge:
  - cfg_start, or a pending request, goes to WR_LO. Config has priority when it coincides with host_req.
  - Otherwise host_req goes to HOST and sets host_gnt=1.
  - Otherwise the FSM stays in IDLE.
- Config acceptance latches div_sel = DIVn[br_cfg]. br_cfg changes after acceptance have no effect.
- Config timing, with cfg_start sampled at edge N:
  - N+1: WR_LO outputs io_addr=2'b10, data_out=div_sel[7:0], baud_write=1, cfg_busy=1.
  - N+2: WR_HI outputs io_addr=2'b11, data_out=div_sel[15:8], baud_write=1.
  - N+3 onward: WAIT_RDY with baud_write=0; io_addr and data_out hold their last values; a wait counter increments each cycle.
- WAIT_RDY exit:
  - buf_rdy sampled high: cfg_done=1 for one cycle at the next edge, cfg_busy=0, return to IDLE.
  - Counter reaches TIMEOUT with no buf_rdy: cfg_err=1 for one cycle instead, cfg_busy=0, return to IDLE.
- HOST state:
  - Each edge registers host_addr→io_addr, host_data→data_out and host_wr→baud_write, giving one cycle of latency.
  - host_req low at an edge: next cycle host_gnt=0 and baud_write=0, then IDLE.
  - Host writes are not checked or counted.
- cfg_start received in HOST, WR_LO, WR_HI or WAIT_RDY:
  - The request is latched as pending with its br_cfg; cfg_busy=1 while pending.
  - It is serviced on the next IDLE, before any host_req.
  - Multiple requests collapse to one, and the latest br_cfg wins.
- The pending request is not serviced until the current owner finishes; the host is never preempted.
- cfg_done and cfg_err are never high together. cfg_busy is low on the cycle either pulse is high, unless a new request is pending.

Test Plan:
- Reset release, AUTO_CFG=1, br_cfg=2'b01: 8'h8A@2'b10 then 8'h02@2'b11 on consecutive cycles with baud_write=1. buf_rdy driven high 2 cycles later → single cfg_done pulse, cfg_busy 1→0.
- cfg_start and host_req in the same IDLE cycle, br_cfg=2'b11: config runs first (8'hA1, 8'h00). host_gnt rises only after cfg_done; host write 8'h55@2'b10 appears one cycle after host_wr.
- cfg_start during HOST ownership (host holds 5 more cycles): no bus change until host_req drops. Then host_gnt falls and the latched divisor is written; cfg_busy stays 1 throughout.
- buf_rdy held low, TIMEOUT=16: cfg_err pulses exactly 16 cycles after entering WAIT_RDY, cfg_done never asserts, FSM returns to IDLE and accepts a host_req.
- rst asserted during WR_HI: all outputs zero asynchronously. After release (AUTO_CFG=1) the full low/high sequence restarts from WR_LO.
- br_cfg toggled 2'b00→2'b10 the cycle after cfg_start: written bytes are 8'h15/8'h05 (DIV0), not DIV2.
